fme_arbiter: RTL and testbench
==============================

// Module: fme_arbiter
// PURPOSE
//  Shares one fast-modular-exponentiation (FME) engine between two requesters: ch0 = encrypt path
//  (public exponent), ch1 = decrypt path (private exponent). Latches each requester's fme_start pulse
//  and block, grants the engine round-robin and drives base/exp/mod with a one-cycle start.
//  Returns the engine result to the granted channel with a one-cycle done pulse. Sits between the
//  byte packers/unpackers and the single FME instance.
// PARAMETERS
//  WIDTH          32     operand/result width (block, exponent, modulus)
//  TIMEOUT_CYCLES 4096   watchdog limit in WAIT (used only with FME_ARB_TIMEOUT_EN)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  n_key       in   WIDTH  shared modulus; sampled at LAUNCH
//  req0_start  in   1      ch0 request pulse; req0_data/req0_exp sampled same cycle
//  req0_data   in   WIDTH  ch0 block (base)
//  req0_exp    in   WIDTH  ch0 exponent
//  req1_start  in   1      ch1 request pulse
//  req1_data   in   WIDTH  ch1 block
//  req1_exp    in   WIDTH  ch1 exponent
//  req0_busy   out  1      ch0 pending or in service; a new pulse is rejected while high
//  req1_busy   out  1      same for ch1
//  done0       out  1      one-cycle pulse, result valid for ch0
//  done1       out  1      one-cycle pulse, result valid for ch1
//  result      out  WIDTH  engine result; held until the next DELIVER
//  req_err     out  1      sticky: a start pulse arrived while that channel was busy; cleared by rst only
//  fme_start   out  1      one-cycle engine start
//  fme_base    out  WIDTH  operand regs to engine, stable from LAUNCH until DELIVER
//  fme_exp     out  WIDTH
//  fme_mod     out  WIDTH
//  fme_done    in   1      engine completion pulse
//  fme_result  in   WIDTH  valid while fme_done is high
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, pend0/1=0, last_grant=1 (ch0 wins first tie), all outputs 0.
//  - Intake (any state): reqN_start while !reqN_busy -> pendN=1, dataN/expN latched; busy is high the next cycle.
//    reqN_start while reqN_busy -> ignored, req_err<=1.
//  - FSM: IDLE -> LAUNCH -> WAIT -> DELIVER -> IDLE.
//    IDLE: if pend0|pend1, pick the channel; if both are pending, pick !last_grant. Load fme_base/exp from
//      that channel, fme_mod<=n_key, grant<=ch, go LAUNCH. Otherwise stay.
//    LAUNCH: fme_start=1 for exactly this cycle; go WAIT.
//    WAIT: on fme_done, result<=fme_result, go DELIVER. fme_done in any other state is ignored.
//    DELIVER: doneN=1 for granted ch, pendN<=0, last_grant<=grant, go IDLE.
//  - A request pulse arriving in IDLE is seen next cycle. fme_start is asserted 2 cycles after the
//    request pulse (req@t, IDLE picks @t+1, fme_start high @t+2). doneN is asserted 1 cycle after fme_done.
//  - The granted channel stays busy until the cycle after doneN. It may re-request from that cycle on.
//  - Simultaneous req0/req1 pulses both latch. Order follows last_grant. Strict alternation under
//    continuous load, no starvation.
//  - Request during DELIVER for the other channel: latched, served after return to IDLE.
//  - Operand regs are not changed by intake during service. Per-channel buffers are separate from engine regs.
//  - rst mid-operation: everything is cleared at once, and an in-flight result is discarded. The engine
//    shares rst.
// CONFIGURATION
//  FME_ARB_TIMEOUT_EN defined: 16-bit wait counter cleared at LAUNCH, increments in WAIT.
//    When the count reaches TIMEOUT_CYCLES-1 with no fme_done: result<=0, req_err<=1, go DELIVER
//    (doneN still pulses, so the requester never hangs).
//  FME_ARB_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely until fme_done.
// TESTING
//  1 Single ch0: req0_start, data=5, exp=3, n_key=33; model returns 5^3 mod 33=26 after 10 cyc
//    -> fme_start @t+2, done0 one cycle, result=26, done1 never.
//  2 Simultaneous req0+req1 after reset -> ch0 served first, then ch1. The next simultaneous pair
//    after a ch1 grant -> ch0 first again (alternation check over 6 pairs).
//  3 req0_start while req0_busy -> ignored, req_err=1 and stays 1. The original ch0 result
//    is still delivered correctly.
//  4 rst asserted in WAIT -> next edge: all outputs 0, busy=0, no doneN. A fresh request after rst
//    completes normally.
//  5 Spurious fme_done in IDLE -> no doneN, result unchanged.
//  6 (FME_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) engine never completes -> done0 pulses 16 cycles
//    after fme_start, result=0, req_err=1.

Source files
------------

// File: rtl/fme_arbiter.sv
// Round-robin sharing of one modular-exponentiation engine between
// two requesters. Optional watchdog: define FME_ARB_TIMEOUT_EN.
module fme_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] n_key,
    input  logic             req0_start,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [WIDTH-1:0] req0_exp,
    input  logic             req1_start,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [WIDTH-1:0] req1_exp,
    output logic             req0_busy,
    output logic             req1_busy,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             req_err,
    output logic             fme_start,
    output logic [WIDTH-1:0] fme_base,
    output logic [WIDTH-1:0] fme_exp,
    output logic [WIDTH-1:0] fme_mod,
    input  logic             fme_done,
    input  logic [WIDTH-1:0] fme_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t           state_q, state_d;
    logic             pend0_q, pend0_d;
    logic             pend1_q, pend1_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] exp0_q, exp0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [WIDTH-1:0] exp1_q, exp1_d;
    logic             last_q, last_d;
    logic             grant_q, grant_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] fexp_q, fexp_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             pick;
    logic             tmo;

`ifdef FME_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wcnt_q, wcnt_d;

    // Counts cycles since the engine start; zero while launching.
    always_comb begin
        wcnt_d = wcnt_q;
        if (state_q == S_IDLE) begin
            wcnt_d = '0;
        end else if (state_q == S_LAUNCH || state_q == S_WAIT) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign tmo = (state_q == S_WAIT) && (wcnt_q == TO_LAST);
`else
    assign tmo = 1'b0;
`endif

    // Intake of request pulses plus next-state and output logic.
    always_comb begin
        state_d  = state_q;
        pend0_d  = pend0_q;
        pend1_d  = pend1_q;
        data0_d  = data0_q;
        exp0_d   = exp0_q;
        data1_d  = data1_q;
        exp1_d   = exp1_q;
        last_d   = last_q;
        grant_d  = grant_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        result_d = result_q;
        err_d    = err_q;
        start_d  = 1'b0;
        base_d   = base_q;
        fexp_d   = fexp_q;
        mod_d    = mod_q;
        pick     = 1'b0;

        if (req0_start) begin
            if (pend0_q) begin
                err_d = 1'b1;
            end else begin
                pend0_d = 1'b1;
                data0_d = req0_data;
                exp0_d  = req0_exp;
            end
        end
        if (req1_start) begin
            if (pend1_q) begin
                err_d = 1'b1;
            end else begin
                pend1_d = 1'b1;
                data1_d = req1_data;
                exp1_d  = req1_exp;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (pend0_q || pend1_q) begin
                    pick    = (pend0_q && pend1_q) ? ~last_q : pend1_q;
                    base_d  = pick ? data1_q : data0_q;
                    fexp_d  = pick ? exp1_q : exp0_q;
                    mod_d   = n_key;
                    grant_d = pick;
                    start_d = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fme_done) begin
                    result_d = fme_result;
                    done0_d  = ~grant_q;
                    done1_d  = grant_q;
                    state_d  = S_DELIVER;
                end else if (tmo) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done0_d  = ~grant_q;
                    done1_d  = grant_q;
                    state_d  = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (grant_q) begin
                    pend1_d = 1'b0;
                end else begin
                    pend0_d = 1'b0;
                end
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; last grant resets to ch1 so ch0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pend0_q  <= 1'b0;
            pend1_q  <= 1'b0;
            data0_q  <= '0;
            exp0_q   <= '0;
            data1_q  <= '0;
            exp1_q   <= '0;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            base_q   <= '0;
            fexp_q   <= '0;
            mod_q    <= '0;
        end else begin
            state_q  <= state_d;
            pend0_q  <= pend0_d;
            pend1_q  <= pend1_d;
            data0_q  <= data0_d;
            exp0_q   <= exp0_d;
            data1_q  <= data1_d;
            exp1_q   <= exp1_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            result_q <= result_d;
            err_q    <= err_d;
            start_q  <= start_d;
            base_q   <= base_d;
            fexp_q   <= fexp_d;
            mod_q    <= mod_d;
        end
    end

    assign req0_busy = pend0_q;
    assign req1_busy = pend1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign result    = result_q;
    assign req_err   = err_q;
    assign fme_start = start_q;
    assign fme_base  = base_q;
    assign fme_exp   = fexp_q;
    assign fme_mod   = mod_q;

endmodule

// File: tb/tb_fme_arbiter.sv
// Directed bench for fme_arbiter with a behavioural exponentiation engine.
// Timeout case runs only when FME_ARB_TIMEOUT_EN is defined.
module tb_fme_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] n_key;
    logic        req0_start;
    logic [31:0] req0_data;
    logic [31:0] req0_exp;
    logic        req1_start;
    logic [31:0] req1_data;
    logic [31:0] req1_exp;
    logic        req0_busy;
    logic        req1_busy;
    logic        done0;
    logic        done1;
    logic [31:0] result;
    logic        req_err;
    logic        fme_start;
    logic [31:0] fme_base;
    logic [31:0] fme_exp;
    logic [31:0] fme_mod;
    logic        fme_done;
    logic [31:0] fme_result;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int n_done0 = 0;
    int n_done1 = 0;
    bit eng_en = 1'b1;
    int spur_req = 0;
    int spur_ack = 0;
    logic [31:0] spur_val = 32'h0;

    fme_arbiter #(
        .WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .n_key(n_key),
        .req0_start(req0_start),
        .req0_data(req0_data),
        .req0_exp(req0_exp),
        .req1_start(req1_start),
        .req1_data(req1_data),
        .req1_exp(req1_exp),
        .req0_busy(req0_busy),
        .req1_busy(req1_busy),
        .done0(done0),
        .done1(done1),
        .result(result),
        .req_err(req_err),
        .fme_start(fme_start),
        .fme_base(fme_base),
        .fme_exp(fme_exp),
        .fme_mod(fme_mod),
        .fme_done(fme_done),
        .fme_result(fme_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (done0 === 1'b1) n_done0++;
        if (done1 === 1'b1) n_done1++;
    end

    function automatic logic [31:0] modexp(input logic [31:0] b,
                                           input logic [31:0] e,
                                           input logic [31:0] m);
        logic [63:0] r;
        logic [63:0] x;
        r = 64'd1 % {32'd0, m};
        x = {32'd0, b} % {32'd0, m};
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % {32'd0, m};
            x = (x * x) % {32'd0, m};
        end
        return r[31:0];
    endfunction

    // Engine model: answers 10 cycles after it sees fme_start.
    initial begin
        int          cnt;
        logic [31:0] eb, ee, em;
        cnt = 0;
        eb = 0;
        ee = 0;
        em = 1;
        fme_done = 1'b0;
        fme_result = 32'h0;
        forever begin
            @(negedge clk);
            fme_done = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (spur_req != spur_ack) begin
                spur_ack = spur_req;
                fme_done = 1'b1;
                fme_result = spur_val;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    fme_done = 1'b1;
                    fme_result = modexp(eb, ee, em);
                end
            end else if (fme_start && eng_en) begin
                eb = fme_base;
                ee = fme_exp;
                em = fme_mod;
                cnt = 10;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; drives pulses for one cycle, returns at the next negedge.
    task automatic req(input bit r0, input bit r1,
                       input logic [31:0] d0, input logic [31:0] e0,
                       input logic [31:0] d1, input logic [31:0] e1);
        req0_start = r0;
        req0_data = d0;
        req0_exp = e0;
        req1_start = r1;
        req1_data = d1;
        req1_exp = e1;
        @(negedge clk);
        req0_start = 1'b0;
        req1_start = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int ch, output int lat);
        ch = -1;
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                ch = 0;
                lat = cyc - t0;
                break;
            end
            if (done1 === 1'b1) begin
                ch = 1;
                lat = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        int t0;
        int ch;
        int lat;
        int nd0;
        int nd1;
        logic [31:0] r0;
        rst = 1'b1;
        n_key = 32'd33;
        req0_start = 1'b0;
        req1_start = 1'b0;
        req0_data = 0;
        req0_exp = 0;
        req1_data = 0;
        req1_exp = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy0", {31'd0, req0_busy}, 32'd0);
        chk("rst_busy1", {31'd0, req1_busy}, 32'd0);
        chk("rst_done", {30'd0, done1, done0}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_err", {31'd0, req_err}, 32'd0);
        chk("rst_start", {31'd0, fme_start}, 32'd0);
        chk("rst_mod", fme_mod, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single ch0, 5^3 mod 33 = 26
        t0 = cyc;
        req(1, 0, 32'd5, 32'd3, 32'd0, 32'd0);
        chk("t1_busy0", {31'd0, req0_busy}, 32'd1);
        chk("t1_start_early", {31'd0, fme_start}, 32'd0);
        @(negedge clk);
        chk("t1_start", {31'd0, fme_start}, 32'd1);
        chk("t1_base", fme_base, 32'd5);
        chk("t1_exp", fme_exp, 32'd3);
        chk("t1_mod", fme_mod, 32'd33);
        @(negedge clk);
        chk("t1_start_once", {31'd0, fme_start}, 32'd0);
        wait_done(t0, ch, lat);
        chk("t1_ch", ch, 32'd0);
        chk("t1_lat", lat, 32'd13);
        chk("t1_result", result, 32'd26);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, done0}, 32'd0);
        chk("t1_busy_drop", {31'd0, req0_busy}, 32'd0);
        chk("t1_no_done1", n_done1, 32'd0);

        // 2: six simultaneous pairs after reset, ch0 first each time
        do_reset();
        for (int i = 0; i < 6; i++) begin
            t0 = cyc;
            req(1, 1, 32'(2 + i), 32'd3, 32'(3 + i), 32'd5);
            wait_done(t0, ch, lat);
            chk("t2_first_ch", ch, 32'd0);
            chk("t2_first_res", result, modexp(32'(2 + i), 32'd3, 32'd33));
            wait_done(t0, ch, lat);
            chk("t2_second_ch", ch, 32'd1);
            chk("t2_second_res", result, modexp(32'(3 + i), 32'd5, 32'd33));
            @(negedge clk);
        end

        // 3: re-request while busy, 7^3 mod 33 = 13
        nd0 = n_done0;
        t0 = cyc;
        req(1, 0, 32'd7, 32'd3, 32'd0, 32'd0);
        chk("t3_err_clear", {31'd0, req_err}, 32'd0);
        @(negedge clk);
        req(1, 0, 32'd9, 32'd9, 32'd0, 32'd0);
        chk("t3_err_set", {31'd0, req_err}, 32'd1);
        chk("t3_base_kept", fme_base, 32'd7);
        wait_done(t0, ch, lat);
        chk("t3_ch", ch, 32'd0);
        chk("t3_result", result, 32'd13);
        repeat (20) @(negedge clk);
        chk("t3_err_sticky", {31'd0, req_err}, 32'd1);
        chk("t3_one_done", n_done0 - nd0, 32'd1);

        // 4: reset while waiting on the engine
        t0 = cyc;
        req(1, 0, 32'd2, 32'd7, 32'd0, 32'd0);
        repeat (5) @(negedge clk);
        nd0 = n_done0;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_busy0", {31'd0, req0_busy}, 32'd0);
        chk("t4_err", {31'd0, req_err}, 32'd0);
        chk("t4_result", result, 32'd0);
        chk("t4_base", fme_base, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t4_no_done", n_done0 - nd0, 32'd0);
        n_key = 32'd35;
        t0 = cyc;
        req(0, 1, 32'd0, 32'd0, 32'd4, 32'd5);
        wait_done(t0, ch, lat);
        chk("t4_fresh_ch", ch, 32'd1);
        chk("t4_fresh_res", result, 32'd9);
        repeat (3) @(negedge clk);

        // 5: spurious engine done while idle
        nd0 = n_done0;
        nd1 = n_done1;
        r0 = result;
        spur_val = 32'hDEAD;
        spur_req++;
        repeat (6) @(negedge clk);
        chk("t5_no_done", (n_done0 - nd0) + (n_done1 - nd1), 32'd0);
        chk("t5_result", result, 32'd9);
        chk("t5_result_held", result, r0);

`ifdef FME_ARB_TIMEOUT_EN
        // 6: engine never answers; watchdog delivers zero
        do_reset();
        eng_en = 1'b0;
        t0 = cyc;
        req(1, 0, 32'd5, 32'd3, 32'd0, 32'd0);
        wait_done(t0, ch, lat);
        chk("t6_ch", ch, 32'd0);
        chk("t6_lat", lat, 32'd18);
        chk("t6_result", result, 32'd0);
        chk("t6_err", {31'd0, req_err}, 32'd1);
        eng_en = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
